// File: rtl/track_recorder.sv
// Record-mode writer for the four track pattern RAMs: samples the fret keys once per
// game step and packs four consecutive steps per track into one 4-bit word per address.
module track_recorder #(
    parameter logic [6:0] LAST_ADDR = 7'd127
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       step_tick,
    input  logic       record_en,
    input  logic [3:0] KEY,
    output logic [6:0] wr_addr,
    output logic [3:0] track1_data,
    output logic [3:0] track2_data,
    output logic [3:0] track3_data,
    output logic [3:0] track4_data,
    output logic       wren,
    output logic       recording,
    output logic       done,
    output logic [1:0] step_idx
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RECORD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state;

    // Bit t of every per-key vector belongs to track t+1, so KEY[3] lands in bit 0.
    logic [3:0]      key_meta;
    logic [3:0]      press;
    logic [3:0]      sticky;
    logic [3:0]      slot;
    logic [3:0][3:0] pack;
    logic [3:0][3:0] pack_next;
    logic [3:0][3:0] word;
    logic            wren_d;

    assign slot = sticky | press;

    // NOTE: always_comb starts from a full default so no path leaves pack_next unassigned (no latch).
    always_comb begin
        pack_next = pack;
        for (int t = 0; t < 4; t++) begin
            pack_next[t][step_idx] = slot[t];
        end
    end

    assign track1_data = word[0];
    assign track2_data = word[1];
    assign track3_data = word[2];
    assign track4_data = word[3];

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            key_meta  <= '0;
            press     <= '0;
            sticky    <= '0;
            pack      <= '0;
            word      <= '0;
            wr_addr   <= '0;
            wren      <= 1'b0;
            wren_d    <= 1'b0;
            recording <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
        end else begin
            // Inverting ahead of the synchronizer keeps the reset value meaning "no press".
            key_meta <= ~{KEY[0], KEY[1], KEY[2], KEY[3]};
            press    <= key_meta;

            // NOTE: wren defaults low here and is raised only by the branches that issue a write.
            wren   <= 1'b0;
            wren_d <= wren;
            // Address advances one cycle after the pulse so it holds through the RAM hold window.
            if (wren_d && (wr_addr != LAST_ADDR)) begin
                wr_addr <= wr_addr + 7'd1;
            end

            case (state)
                S_IDLE: begin
                    if (record_en) begin
                        state     <= S_ARM;
                        recording <= 1'b1;
                        wr_addr   <= '0;
                        step_idx  <= '0;
                        sticky    <= '0;
                        pack      <= '0;
                    end
                end

                S_ARM: begin
                    if (!record_en) begin
                        state     <= S_IDLE;
                        recording <= 1'b0;
                    end else if (step_tick) begin
                        state <= S_RECORD;
                    end
                end

                S_RECORD: begin
                    if (!record_en) begin
                        recording <= 1'b0;
                        if (step_idx == 2'd0) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_FLUSH;
                            word  <= pack;
                            wren  <= 1'b1;
                        end
                    end else if (step_tick) begin
                        sticky <= '0;
                        if (step_idx == 2'd3) begin
                            word     <= pack_next;
                            wren     <= 1'b1;
                            pack     <= '0;
                            step_idx <= '0;
                            if (wr_addr == LAST_ADDR) begin
                                state     <= S_DONE;
                                recording <= 1'b0;
                                done      <= 1'b1;
                            end
                        end else begin
                            pack     <= pack_next;
                            step_idx <= step_idx + 2'd1;
                        end
                    end else begin
                        sticky <= slot;
                    end
                end

                S_FLUSH: begin
                    pack     <= '0;
                    step_idx <= '0;
                    sticky   <= '0;
                    if (wr_addr == LAST_ADDR) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_DONE: begin
                    if (!record_en) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
